// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_RETRY = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  // Clears the byte-offset bits so a redirect always lands on a word.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump beats branch beats sequential, with word alignment of redirects.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  output logic [XLEN-1:0] o_next_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_misalign_hit
);

  logic [XLEN-1:0] w_pcPlus4;

  assign w_pcPlus4  = i_pc + PC_STEP;
  assign o_pc_plus4 = w_pcPlus4;

  // The misalign hit only reflects the target that actually wins selection.
  always_comb begin
    o_next_pc      = w_pcPlus4;
    o_misalign_hit = 1'b0;
    if (i_jump) begin
      o_next_pc      = alignWord(i_jump_target);
      o_misalign_hit = |i_jump_target[1:0];
    end else if (i_branch_taken) begin
      o_next_pc      = alignWord(i_branch_target);
      o_misalign_hit = |i_branch_target[1:0];
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch with timeout/retry,
// handing each instruction to decode over a valid/ready handshake.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [ILEN-1:0] imem_data_i,
  output logic [ILEN-1:0] instr_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [3:0]      pc_upper_o,
  output logic            misalign_o,
  output logic            timeout_o
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t    r_state;
  fetch_state_t    w_nextState;
  logic [XLEN-1:0] r_pc;
  logic [ILEN-1:0] r_instr;
  logic [7:0]      r_waitCnt;
  logic            r_misalign;
  logic            r_timeout;

  logic [XLEN-1:0] w_nextPc;
  logic [XLEN-1:0] w_pcPlus4;
  logic            w_misalignHit;
  logic            w_accept;
  logic            w_waitExpired;

  pc_next_sel u_pc_next_sel (
    .i_pc            (r_pc),
    .i_jump          (jump_i),
    .i_jump_target   (jump_target_i),
    .i_branch_taken  (branch_taken_i),
    .i_branch_target (branch_target_i),
    .o_next_pc       (w_nextPc),
    .o_pc_plus4      (w_pcPlus4),
    .o_misalign_hit  (w_misalignHit)
  );

  assign w_accept      = (r_state == ST_VALID) && instr_ready_i;
  assign w_waitExpired = (r_state == ST_FETCH) && !imem_ack_i && (r_waitCnt == WAIT_LAST);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FETCH: begin
        if (imem_ack_i)         w_nextState = ST_VALID;
        else if (w_waitExpired) w_nextState = ST_RETRY;
      end
      ST_RETRY: w_nextState = ST_FETCH;
      ST_VALID: if (instr_ready_i) w_nextState = ST_FETCH;
      default:  w_nextState = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_waitCnt  <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_FETCH) begin
        if (imem_ack_i) begin
          r_instr   <= imem_data_i;
          r_waitCnt <= '0;
        end else if (w_waitExpired) begin
          r_waitCnt <= '0;
          r_timeout <= 1'b1;
        end else begin
          r_waitCnt <= r_waitCnt + 8'd1;
        end
      end
      if (w_accept) begin
        r_pc <= w_nextPc;
        if (w_misalignHit) r_misalign <= 1'b1;
      end
    end
  end

  // Request is gated by reset so a pending fetch disappears the moment reset is seen.
  assign imem_req_o    = (r_state == ST_FETCH) && !rst_i;
  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign instr_valid_o = (r_state == ST_VALID);
  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pcPlus4;
  assign pc_upper_o    = w_pcPlus4[31:28];
  assign misalign_o    = r_misalign;
  assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, redirect priority, backpressure,
// timeout/retry, misaligned branch, wrap-around and mid-operation reset.
module tb_pc_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = '0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [3:0]  pc_upper_o;
  logic        misalign_o;
  logic        timeout_o;

  int vecCount  = 0;
  int missCount = 0;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .pc_upper_o      (pc_upper_o),
    .misalign_o      (misalign_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    imem_ack_i = 1'b1;
    tick();
    tick();
    vecCount++;
    if (imem_req_o !== 1'b0) begin missCount++; $display("FAIL reset_req got=%b want=0", imem_req_o); end
    vecCount++;
    if (instr_valid_o !== 1'b0) begin missCount++; $display("FAIL reset_valid got=%b want=0", instr_valid_o); end
    vecCount++;
    if (instr_o !== 32'h0) begin missCount++; $display("FAIL reset_instr got=%h want=0", instr_o); end
    vecCount++;
    if ({misalign_o, timeout_o} !== 2'b00) begin missCount++; $display("FAIL reset_flags got=%b want=00", {misalign_o, timeout_o}); end
    imem_ack_i = 1'b0;
    rst_i = 1'b0;
    #1;
    vecCount++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      missCount++; $display("FAIL reset_first_req got=%b/%h want=1/00000000", imem_req_o, imem_addr_o);
    end
    vecCount++;
    if (pc_plus4_o !== 32'h4) begin missCount++; $display("FAIL reset_plus4 got=%h want=00000004", pc_plus4_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] expAddr;
    imem_ack_i = 1'b1;
    instr_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expAddr = 32'(k * 4);
      imem_data_i = memWord(expAddr);
      vecCount++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== expAddr || instr_valid_o !== 1'b0) begin
        missCount++; $display("FAIL seq_req%0d got=%b/%h/%b want=1/%h/0", k, imem_req_o, imem_addr_o, instr_valid_o, expAddr);
      end
      tick();
      vecCount++;
      if (instr_valid_o !== 1'b1 || instr_o !== memWord(expAddr) || imem_req_o !== 1'b0) begin
        missCount++; $display("FAIL seq_valid%0d got=%b/%h/%b want=1/%h/0", k, instr_valid_o, instr_o, imem_req_o, memWord(expAddr));
      end
      vecCount++;
      if (pc_upper_o !== 4'h0) begin missCount++; $display("FAIL seq_upper%0d got=%h want=0", k, pc_upper_o); end
      tick();
    end
    vecCount++;
    if (imem_addr_o !== 32'h10) begin missCount++; $display("FAIL seq_end got=%h want=00000010", imem_addr_o); end
  endtask

  task automatic test_jump_priority();
    imem_ack_i = 1'b1;
    instr_ready_i = 1'b1;
    tick();
    jump_i = 1'b1; jump_target_i = 32'h0040_0010;
    tick();
    jump_i = 1'b0;
    vecCount++;
    if (imem_addr_o !== 32'h0040_0010) begin missCount++; $display("FAIL jump_setup got=%h want=00400010", imem_addr_o); end
    tick();
    jump_i = 1'b1; jump_target_i = 32'h0040_0100;
    branch_taken_i = 1'b1; branch_target_i = 32'h0040_0020;
    tick();
    jump_i = 1'b0; branch_taken_i = 1'b0;
    vecCount++;
    if (imem_addr_o !== 32'h0040_0100) begin missCount++; $display("FAIL jump_prio got=%h want=00400100", imem_addr_o); end
    vecCount++;
    if (misalign_o !== 1'b0) begin missCount++; $display("FAIL jump_misalign got=%b want=0", misalign_o); end
  endtask

  task automatic test_backpressure();
    instr_ready_i = 1'b0;
    imem_ack_i = 1'b1;
    imem_data_i = 32'h1234_5678;
    tick();
    // Redirect inputs during stall must be ignored.
    jump_i = 1'b1; jump_target_i = 32'h0000_0800;
    for (int i = 0; i < 5; i++) begin
      imem_data_i = 32'hDEAD_0000 + 32'(i);
      #1;
      vecCount++;
      if (instr_o !== 32'h1234_5678 || instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 32'h0040_0100) begin
        missCount++; $display("FAIL bp_hold%0d got=%h/%b/%b/%h want=12345678/1/0/00400100", i, instr_o, instr_valid_o, imem_req_o, pc_o);
      end
      tick();
    end
    jump_i = 1'b0;
    instr_ready_i = 1'b1;
    tick();
    vecCount++;
    if (pc_o !== 32'h0040_0104 || imem_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin
      missCount++; $display("FAIL bp_advance got=%h/%b/%b want=00400104/1/0", pc_o, imem_req_o, instr_valid_o);
    end
  endtask

  task automatic test_timeout();
    imem_ack_i = 1'b0;
    vecCount++;
    if (timeout_o !== 1'b0) begin missCount++; $display("FAIL to_before got=%b want=0", timeout_o); end
    for (int i = 0; i < 4; i++) begin
      vecCount++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0104) begin
        missCount++; $display("FAIL to_req%0d got=%b/%h want=1/00400104", i, imem_req_o, imem_addr_o);
      end
      tick();
    end
    // Ack during the retry gap must not be taken.
    imem_ack_i = 1'b1;
    #1;
    vecCount++;
    if (imem_req_o !== 1'b0 || timeout_o !== 1'b1) begin
      missCount++; $display("FAIL to_retry got=%b/%b want=0/1", imem_req_o, timeout_o);
    end
    tick();
    imem_ack_i = 1'b0;
    #1;
    vecCount++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0104 || instr_valid_o !== 1'b0) begin
      missCount++; $display("FAIL to_reissue got=%b/%h/%b want=1/00400104/0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    imem_ack_i = 1'b1;
    instr_ready_i = 1'b0;
    tick();
    vecCount++;
    if (timeout_o !== 1'b1 || instr_valid_o !== 1'b1) begin
      missCount++; $display("FAIL to_sticky got=%b/%b want=1/1", timeout_o, instr_valid_o);
    end
  endtask

  task automatic test_misalign();
    instr_ready_i = 1'b1;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0106;
    tick();
    branch_taken_i = 1'b0;
    vecCount++;
    if (imem_addr_o !== 32'h0000_0104 || misalign_o !== 1'b1) begin
      missCount++; $display("FAIL mis_branch got=%h/%b want=00000104/1", imem_addr_o, misalign_o);
    end
    tick();
    tick();
    vecCount++;
    if (imem_addr_o !== 32'h0000_0108 || misalign_o !== 1'b1) begin
      missCount++; $display("FAIL mis_sticky got=%h/%b want=00000108/1", imem_addr_o, misalign_o);
    end
  endtask

  task automatic test_wrap_and_reset();
    tick();
    jump_i = 1'b1; jump_target_i = 32'hFFFF_FFF8;
    tick();
    jump_i = 1'b0;
    vecCount++;
    if (pc_plus4_o !== 32'hFFFF_FFFC || pc_upper_o !== 4'hF) begin
      missCount++; $display("FAIL wrap_upper got=%h/%h want=fffffffc/f", pc_plus4_o, pc_upper_o);
    end
    tick();
    tick();
    vecCount++;
    if (imem_addr_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
      missCount++; $display("FAIL wrap_last got=%h/%h want=fffffffc/00000000", imem_addr_o, pc_plus4_o);
    end
    tick();
    tick();
    vecCount++;
    if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin
      missCount++; $display("FAIL wrap_zero got=%h/%b want=00000000/1", imem_addr_o, imem_req_o);
    end
    tick();
    tick();
    vecCount++;
    if (pc_o !== 32'h4) begin missCount++; $display("FAIL midrst_pre got=%h want=00000004", pc_o); end
    rst_i = 1'b1;
    imem_data_i = 32'hBAD0_BAD0;
    #1;
    vecCount++;
    if (imem_req_o !== 1'b0) begin missCount++; $display("FAIL midrst_req got=%b want=0", imem_req_o); end
    tick();
    vecCount++;
    if (instr_valid_o !== 1'b0 || pc_o !== 32'h0 || misalign_o !== 1'b0 || timeout_o !== 1'b0 || instr_o !== 32'h0) begin
      missCount++; $display("FAIL midrst_state got=%b/%h/%b/%b/%h want=0/00000000/0/0/00000000",
                            instr_valid_o, pc_o, misalign_o, timeout_o, instr_o);
    end
    rst_i = 1'b0;
    imem_ack_i = 1'b0;
    #1;
    vecCount++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      missCount++; $display("FAIL midrst_resume got=%b/%h want=1/00000000", imem_req_o, imem_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_priority();
    test_backpressure();
    test_timeout();
    test_misalign();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Holds the program counter and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Hands each fetched instruction to decode over a valid/ready handshake.
- On acceptance, selects the next PC from three sources, in priority order: jump target, branch target, PC+4.
- Supplies PC+4 and its upper nibble to the jump-address formation stage, and consumes that stage's 32-bit jump target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- TIMEOUT, 16, cycles in FETCH without imem_ack_i before the request is abandoned and retried (range 2..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous active-high
- imem_req_o  out  1  fetch request to instruction memory
- imem_addr_o  out  32  fetch address (equals pc_o)
- imem_ack_i  in  1  memory returns imem_data_i this cycle
- imem_data_i  in  32  instruction word
- instr_o  out  32  registered instruction to decode
- instr_valid_o  out  1  instr_o is valid
- instr_ready_i  in  1  decode accepts instr_o
- jump_i  in  1  accepted instruction is a jump
- jump_target_i  in  32  target from jump-address formation stage
- branch_taken_i  in  1  accepted instruction is a taken branch
- branch_target_i  in  32  branch target
- pc_o  out  32  current PC
- pc_plus4_o  out  32  pc_o + 4, modulo 2^32
- pc_upper_o  out  4  pc_plus4_o[31:28]
- misalign_o  out  1  sticky: a redirect target had nonzero bits [1:0]
- timeout_o  out  1  sticky: at least one fetch timed out

Behaviour:
- Reset, cycle with rst_i=1:
  - pc=RESET_PC, state=FETCH, instr_o=0, instr_valid_o=0.
  - misalign_o=0, timeout_o=0, wait counter=0.
  - imem_req_o=0 while rst_i=1.
- States: FETCH, RETRY, VALID.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - If imem_ack_i=1: register instr_o<=imem_data_i, clear counter, go to VALID. Minimum latency is 1 cycle from req to instr_valid_o.
  - If imem_ack_i=0: counter+1. When the counter reaches TIMEOUT-1 without ack: set timeout_o, clear counter, go to RETRY.
- RETRY:
  - imem_req_o=0 for exactly one cycle, then back to FETCH at the same pc.
  - imem_ack_i is ignored in RETRY.
- VALID:
  - instr_valid_o=1; instr_o is held stable until accepted.
  - Acceptance is instr_valid_o & instr_ready_i. On acceptance, pc <= next_pc and state=FETCH.
  - next_pc priority: jump_i → jump_target_i; else branch_taken_i → branch_target_i; else pc+4.
  - jump_i and branch_taken_i both 1: jump wins.
  - jump_i, branch_taken_i and the target inputs are sampled only on the acceptance cycle and ignored otherwise.
- Alignment: a selected redirect target has bits [1:0] forced to 0 before loading pc. If the original bits were nonzero, misalign_o is set (sticky until reset).
- Wrap-around: PC+4 from 32'hFFFF_FFFC yields 32'h0000_0000, with no flag.
- Combinational outputs: pc_o, imem_addr_o, pc_plus4_o and pc_upper_o are combinational from the pc register. They update the cycle after acceptance.
- Reset mid-operation: rst_i has priority in any state. An outstanding request is dropped, and a late imem_ack_i in the reset cycle is ignored.
- No combinational path from instr_ready_i to imem_req_o.

Decomposition:
- Shared package (cpu_pkg):
  - state enum FETCH/RETRY/VALID.
  - PC_STEP=4.
  - RESET_PC default.
  - instruction and address width constants (32).
- Natural sub-module: pc_next_sel, combinational. It takes pc, the jump/branch inputs and their targets, and produces next_pc, pc_plus4 and misalign_hit.
- The FSM, wait counter and registers stay in the top block.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: RESET_PC=0; memory acks every request in the same cycle; ready always 1.
  - Required: imem_addr_o = 0, 4, 8, 12 on successive requests; instr_valid_o pulses every 2nd cycle; pc_upper_o=0.
- Jump priority:
  - Stimulus: at pc=32'h0040_0010, accept with jump_i=1, jump_target_i=32'h0040_0100, branch_taken_i=1, branch_target_i=32'h0040_0020.
  - Required: next imem_addr_o=32'h0040_0100; misalign_o stays 0.
- Backpressure:
  - Stimulus: instr_ready_i=0 for 5 cycles while in VALID.
  - Required: instr_o stable; no new imem_req_o; pc unchanged; advances to pc+4 only after ready=1.
- Timeout/retry:
  - Stimulus: TIMEOUT=4; imem_ack_i held 0.
  - Required: req high for 4 cycles, low for 1 cycle, high again at the same address; timeout_o=1 and sticky.
- Misaligned branch:
  - Stimulus: branch_target_i=32'h0000_0106 on acceptance.
  - Required: next imem_addr_o=32'h0000_0104; misalign_o=1 until reset.
- Wrap and mid-op reset:
  - Stimulus 1: pc=32'hFFFF_FFFC, sequential accept. Required: imem_addr_o=0.
  - Stimulus 2: assert rst_i during FETCH with ack arriving that cycle. Required: instr_valid_o=0, pc=RESET_PC, flags cleared.
